mp_serializer_sched: RTL and testbench

Slow-domain scheduler that shares one 256-bit parallel-to-serial lane among several requesters. Every word-clock cycle it fills the serializer's parallel load register with one of three things: a requester's data word (chosen by round-robin, locked for a multi-word burst), an idle filler, or a periodic alignment sync word. It sits directly in front of the serializer input register, clocked by the serializer's slow word clock.

---
 rtl/mp_serializer_sched_if.sv | 32 +++
 rtl/mp_serializer_sched.sv | 158 +++++++++++++++
 tb/tb_mp_serializer_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_serializer_sched_if.sv
// mp_serializer_sched_if: requester handshake plus the registered load-word
// outputs of the serializer scheduler.
//
// Handshake: req_v_i[r] says requester r presents a word on its slice of
// req_data_i together with req_last_i[r]. req_yumi_o[r] is raised in the same
// cycle the word is consumed on the next clock edge. A requester keeps its
// word and last flag stable until it sees yumi, then advances.
interface mp_serializer_sched_if #(
    parameter int width_p   = 256,
    parameter int num_req_p = 4
);
    localparam int id_w_lp = $clog2(num_req_p);

    logic [num_req_p-1:0]         req_v_i;
    logic [num_req_p*width_p-1:0] req_data_i;
    logic [num_req_p-1:0]         req_last_i;
    logic [num_req_p-1:0]         req_yumi_o;
    logic [width_p-1:0]           data_o;
    logic [1:0]                   kind_o;
    logic [id_w_lp-1:0]           grant_id_o;
    logic [1:0]                   state_o;     // scheduler FSM state, for debug

    modport slave (
        input  req_v_i, req_data_i, req_last_i,
        output req_yumi_o, data_o, kind_o, grant_id_o, state_o
    );

    modport master (
        output req_v_i, req_data_i, req_last_i,
        input  req_yumi_o, data_o, kind_o, grant_id_o, state_o
    );
endinterface

// File: rtl/mp_serializer_sched.sv
// mp_serializer_sched: fills the serializer parallel load register every word
// clock with a requester word (round-robin, locked for a burst), an idle
// filler, or a periodic alignment sync word.
// Optional feature: define MP_SER_SCHED_SYNC_EN to build the sync counter and
// sync slots; without it every enabled slot carries data or idle.
module mp_serializer_sched #(
    parameter int                 width_p        = 256,
    parameter int                 num_req_p      = 4,
    parameter int                 sync_period_p  = 1024,
    parameter logic [width_p-1:0] idle_pattern_p = {128{2'b10}},
    parameter logic [width_p-1:0] sync_pattern_p = {32{8'hBC}}
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    mp_serializer_sched_if.slave  bus
);
    localparam int         id_w_lp     = $clog2(num_req_p);
    localparam logic [1:0] kind_idle_lp = 2'd0;
    localparam logic [1:0] kind_data_lp = 2'd1;
    localparam logic [1:0] kind_sync_lp = 2'd2;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ARB  = 2'd1,
        LOCK = 2'd2
    } state_e;

    state_e             state_r;
    logic [id_w_lp-1:0] rr_ptr_r;
    logic [id_w_lp-1:0] owner_r;

    logic               sync_due;
    logic               grant_v;
    logic [id_w_lp-1:0] grant_id;
    logic               take;
    logic               grant_last;
    logic [width_p-1:0] grant_data;
    int                 scan_idx;

`ifdef MP_SER_SCHED_SYNC_EN
    localparam int cnt_w_lp = $clog2(sync_period_p);

    logic [cnt_w_lp-1:0] sync_cnt_r;
    logic [cnt_w_lp-1:0] sync_cnt_eff;
    logic                en_q_r;

    // A rising en_i restarts the sync interval, so that slot is itself a sync slot.
    always_comb begin
        sync_cnt_eff = (en_i && !en_q_r) ? '0 : sync_cnt_r;
        sync_due     = (sync_cnt_eff == '0);
    end

    // Sync counter advances once per enabled slot and freezes while disabled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_cnt_r <= '0;
            en_q_r     <= 1'b0;
        end else begin
            en_q_r <= en_i;
            if (en_i) begin
                if (sync_cnt_eff == cnt_w_lp'(sync_period_p - 1))
                    sync_cnt_r <= '0;
                else
                    sync_cnt_r <= sync_cnt_eff + 1'b1;
            end
        end
    end
`else
    assign sync_due = 1'b0;
`endif

    // Grant candidate: the lock owner in LOCK, otherwise the first valid
    // requester at or after rr_ptr (descending scan so the nearest wins).
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        scan_idx = 0;
        if (state_r == LOCK) begin
            grant_v  = bus.req_v_i[owner_r];
            grant_id = owner_r;
        end else begin
            for (int i = num_req_p - 1; i >= 0; i--) begin
                scan_idx = (int'(rr_ptr_r) + i) % num_req_p;
                if (bus.req_v_i[scan_idx]) begin
                    grant_v  = 1'b1;
                    grant_id = id_w_lp'(scan_idx);
                end
            end
        end
    end

    // A word is taken only on an enabled, non-sync, non-reset slot.
    always_comb begin
        take       = en_i && !reset_i && !sync_due && grant_v;
        grant_last = bus.req_last_i[grant_id];
        grant_data = bus.req_data_i[grant_id*width_p +: width_p];
        for (int r = 0; r < num_req_p; r++)
            bus.req_yumi_o[r] = take && (grant_id == id_w_lp'(r));
    end

    assign bus.state_o = state_r;

    // Scheduler FSM and registered load word, slot kind and source id.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r        <= OFF;
            rr_ptr_r       <= '0;
            owner_r        <= '0;
            bus.data_o     <= idle_pattern_p;
            bus.kind_o     <= kind_idle_lp;
            bus.grant_id_o <= '0;
        end else if (!en_i) begin
            bus.data_o     <= idle_pattern_p;
            bus.kind_o     <= kind_idle_lp;
            bus.grant_id_o <= '0;
        end else begin
            if (state_r == OFF)
                state_r <= ARB;
            if (sync_due) begin
`ifdef MP_SER_SCHED_SYNC_EN
                bus.data_o     <= sync_pattern_p;
                bus.kind_o     <= kind_sync_lp;
`else
                bus.data_o     <= idle_pattern_p;
                bus.kind_o     <= kind_idle_lp;
`endif
                bus.grant_id_o <= '0;
            end else if (take) begin
                bus.data_o     <= grant_data;
                bus.kind_o     <= kind_data_lp;
                bus.grant_id_o <= grant_id;
                if (grant_last) begin
                    state_r <= ARB;
                    if (grant_id == id_w_lp'(num_req_p - 1))
                        rr_ptr_r <= '0;
                    else
                        rr_ptr_r <= grant_id + 1'b1;
                end else begin
                    state_r <= LOCK;
                    owner_r <= grant_id;
                end
            end else begin
                bus.data_o     <= idle_pattern_p;
                bus.kind_o     <= kind_idle_lp;
                bus.grant_id_o <= '0;
            end
        end
    end

`ifndef MP_SER_SCHED_SYNC_EN
    // Keeps the sync word and its slot type visible to elaboration in the
    // data-only build without creating any logic.
    localparam logic [width_p-1:0] unused_sync_lp = sync_pattern_p;
    localparam logic [1:0]         unused_kind_lp = kind_sync_lp;
    localparam int                 unused_per_lp  = sync_period_p;
`endif
endmodule

// File: tb/tb_mp_serializer_sched.sv
// tb_mp_serializer_sched: directed scenarios for mp_serializer_sched with a
// queue-based requester/slot model and literal order checks.
module tb_mp_serializer_sched;
    localparam int W = 256;
    localparam int N = 4;
    localparam int P = 4;
    localparam logic [W-1:0] IDLE = {128{2'b10}};
    localparam logic [W-1:0] SYNC = {32{8'hBC}};
`ifdef MP_SER_SCHED_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } word_t;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    logic tb_en = 1'b0;

    mp_serializer_sched_if #(.width_p(W), .num_req_p(N)) bus ();

    mp_serializer_sched #(
        .width_p(W), .num_req_p(N), .sync_period_p(P),
        .idle_pattern_p(IDLE), .sync_pattern_p(SYNC)
    ) dut (
        .clk_i(clk), .reset_i(tb_rst), .en_i(tb_en), .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // requester queues and model state
    word_t        wq [N][$];
    int           total = 0;
    int           bad = 0;
    int           tag = 0;
    logic [1:0]   exp_q[$];
    logic [1:0]   gid_seq[$];
    logic [1:0]   kind_seq[$];
    logic [N-1:0] last_yumi;

    bit           m_lock = 0;
    int           m_owner = 0;
    int           m_rr = 0;
    bit           m_prev_en = 0;
    int           m_slot = 0;
    logic [W-1:0] e_data = IDLE;
    logic [1:0]   e_kind = 0;
    logic [1:0]   e_gid = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    function automatic logic [W-1:0] mk_word(input int r, input int t);
        logic [31:0] s;
        s = {8'(r), 8'(t), 16'hA5C3};
        return {8{s}};
    endfunction

    task automatic push_burst(input int r, input int n);
        for (int k = 0; k < n; k++) begin
            tag++;
            wq[r].push_back('{mk_word(r, tag), (k == n - 1)});
        end
    endtask

    // One slot: drive queue heads, check yumi against the model, advance the
    // model, then check the registered outputs after the edge.
    task automatic step();
        logic [N-1:0] exp_yumi;
        bit           is_sync;
        int           pick;
        word_t        w;
        for (int r = 0; r < N; r++) begin
            bus.req_v_i[r] = (wq[r].size() > 0);
            bus.req_data_i[r*W +: W] = (wq[r].size() > 0) ? wq[r][0].d : '0;
            bus.req_last_i[r] = (wq[r].size() > 0) ? wq[r][0].l : 1'b0;
        end
        #1;
        exp_yumi = '0;
        if (tb_rst) begin
            m_lock = 0; m_owner = 0; m_rr = 0; m_prev_en = 0; m_slot = 0;
            e_data = IDLE; e_kind = 0; e_gid = 0;
        end else if (!tb_en) begin
            m_prev_en = 0;
            e_data = IDLE; e_kind = 0; e_gid = 0;
        end else begin
            if (!m_prev_en) m_slot = 0;
            m_prev_en = 1;
            is_sync = SYNC_ON && (m_slot % P == 0);
            m_slot++;
            pick = -1;
            if (!is_sync) begin
                if (m_lock) begin
                    if (wq[m_owner].size() > 0) pick = m_owner;
                end else begin
                    for (int i = 0; i < N; i++)
                        if (pick < 0 && wq[(m_rr + i) % N].size() > 0) pick = (m_rr + i) % N;
                end
            end
            if (is_sync) begin
                e_data = SYNC; e_kind = 2; e_gid = 0;
            end else if (pick >= 0) begin
                w = wq[pick].pop_front();
                exp_yumi[pick] = 1'b1;
                e_data = w.d; e_kind = 1; e_gid = 2'(pick);
                if (w.l) begin
                    m_lock = 0; m_rr = (pick + 1) % N;
                end else begin
                    m_lock = 1; m_owner = pick;
                end
            end else begin
                e_data = IDLE; e_kind = 0; e_gid = 0;
            end
        end
        last_yumi = bus.req_yumi_o;
        chk("yumi", W'(bus.req_yumi_o), W'(exp_yumi));
        @(posedge clk);
        #1;
        chk("data", bus.data_o, e_data);
        chk("kind", W'(bus.kind_o), W'(e_kind));
        chk("gid", W'(bus.grant_id_o), W'(e_gid));
        kind_seq.push_back(bus.kind_o);
        if (bus.kind_o == 2'd1) gid_seq.push_back(bus.grant_id_o);
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        tb_en = 1'b0;
        step();
        step();
        tb_rst = 1'b0;
        gid_seq.delete();
        kind_seq.delete();
    endtask

    // scoreboard: recorded grant order against a hand-written expected queue
    task automatic chk_gids(input string name);
        chk({name, "_len"}, W'(gid_seq.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < gid_seq.size(); i++)
            chk(name, W'(gid_seq[i]), W'(exp_q[i]));
    endtask

    initial begin
        bus.req_v_i = '0;
        bus.req_data_i = '0;
        bus.req_last_i = '0;
        @(posedge clk);
        #1;

        // reset values
        do_reset();
        chk("rst_data", bus.data_o, IDLE);
        chk("rst_kind", W'(bus.kind_o), W'(0));
        chk("rst_state", W'(bus.state_o), W'(0));

        // enable with no requests: sync cadence or all idle
        tb_en = 1'b1;
        repeat (6) step();
        if (SYNC_ON) exp_q = '{2, 0, 0, 0, 2, 0};
        else         exp_q = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) chk("idle_kind_seq", W'(kind_seq[i]), W'(exp_q[i]));

        // all four requesters with single-word bursts: pure rotation
        do_reset();
        for (int r = 0; r < N; r++) push_burst(r, 1);
        for (int r = 0; r < N; r++) push_burst(r, 1);
        tb_en = 1'b1;
        repeat (12) step();
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_gids("rotate");

        // 5-word burst from requester 1 while 0 and 2 are valid
        do_reset();
        push_burst(0, 1); push_burst(0, 1);
        push_burst(1, 5);
        push_burst(2, 1);
        tb_en = 1'b1;
        repeat (14) step();
        exp_q = '{0, 1, 1, 1, 1, 1, 2, 0};
        chk_gids("burst5");

        // 6-word burst from requester 3, others join after the lock
        do_reset();
        push_burst(3, 6);
        tb_en = 1'b1;
        repeat (2) step();
        push_burst(0, 1); push_burst(1, 1);
        repeat (12) step();
        exp_q = '{3, 3, 3, 3, 3, 3, 0, 1};
        chk_gids("burst6");

        // en_i dropped for three slots mid-burst
        do_reset();
        push_burst(2, 6);
        tb_en = 1'b1;
        repeat (2) step();
        push_burst(1, 1);
        step();
        tb_en = 1'b0;
        repeat (3) begin
            step();
            chk("en_low_kind", W'(bus.kind_o), W'(0));
            chk("en_low_yumi", W'(last_yumi), W'(0));
        end
        tb_en = 1'b1;
        step();
        chk("en_rise_kind", W'(bus.kind_o), SYNC_ON ? W'(2) : W'(1));
        repeat (8) step();
        exp_q = '{2, 2, 2, 2, 2, 2, 1};
        chk_gids("en_pause");

        // reset while locked to requester 2
        do_reset();
        push_burst(2, 4);
        tb_en = 1'b1;
        repeat (3) step();
        push_burst(0, 1);
        tb_rst = 1'b1;
        step();
        chk("lock_rst_kind", W'(bus.kind_o), W'(0));
        chk("lock_rst_data", bus.data_o, IDLE);
        chk("lock_rst_yumi", W'(last_yumi), W'(0));
        tb_rst = 1'b0;
        gid_seq.delete();
        repeat (8) step();
        if (SYNC_ON) exp_q = '{0, 2, 2};
        else         exp_q = '{0, 2};
        chk_gids("lock_rst");

        // lock holds while the owner has nothing to send
        do_reset();
        wq[1].push_back('{mk_word(1, 200), 1'b0});
        tb_en = 1'b1;
        repeat (3) step();
        push_burst(0, 1);
        repeat (3) step();
        wq[1].push_back('{mk_word(1, 201), 1'b1});
        repeat (4) step();
        exp_q = '{1, 1, 0};
        chk_gids("lock_hold");

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
